// File: rtl/ball_motion_ctrl_pkg.sv
// ball_motion_ctrl_pkg: state encoding, requester indices and position width
// shared by the bouncing-ball controller, its interface and its arbiter.
package ball_motion_ctrl_pkg;
    localparam int POS_W = 9;
    typedef logic [POS_W-1:0] pos_t;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;
    localparam int REQ_WALL_SIDE = 0;
    localparam int REQ_WALL_TOP  = 1;
    localparam int REQ_PADDLE    = 2;
    localparam int REQ_BRICK     = 3;
    // Two's complement velocity from a sign flag (1 = negative) and a 1..3 magnitude.
    function automatic pos_t vel(input logic neg, input logic [1:0] speed);
        pos_t mag;
        mag = {{(POS_W-2){1'b0}}, speed};
        return neg ? -mag : mag;
    endfunction
endpackage

// File: rtl/ball_motion_ctrl_if.sv
// ball_motion_ctrl_if: frame sync, serve, collision handshake and ball status
// bundle between game logic (master) and the motion controller (slave).
interface ball_motion_ctrl_if #(parameter int NREQ = 4);
    import ball_motion_ctrl_pkg::*;
    logic            vsync;
    logic            serve;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] req_axis;
    logic [NREQ-1:0] grant;
    pos_t            ball_x;
    pos_t            ball_y;
    logic            ball_active;
    logic            frame_done;
    logic            miss;
    modport master (
        output vsync, serve, req, req_axis,
        input  grant, ball_x, ball_y, ball_active, frame_done, miss
    );
    modport slave (
        input  vsync, serve, req, req_axis,
        output grant, ball_x, ball_y, ball_active, frame_done, miss
    );
endinterface

// File: rtl/ball_motion_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a one-hot combinational winner; the
// search starts just past the last winner and the pointer only moves on a win.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    logic [PW-1:0] ptr_q, ptr_d;
    int idx;
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (en && req[idx] && gnt == '0) begin
                gnt[idx] = 1'b1;
                ptr_d    = PW'((idx + 1) % N);
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-frame ball position/velocity update with arbitrated collisions.
// Define BALL_SPEEDUP_EN to raise speed after every eighth paddle grant.
module ball_motion_ctrl
    import ball_motion_ctrl_pkg::*;
#(
    parameter pos_t X_START = 9'd128,
    parameter pos_t Y_START = 9'd120,
    parameter pos_t Y_MAX   = 9'd239,
    parameter int   NREQ    = 4
) (
    input logic               clk,
    input logic               reset,
    ball_motion_ctrl_if.slave bus
);
    localparam pos_t X_LIM = 9'd255;
    logic [1:0]      state_q, state_d;
    logic            vsync_q;
    pos_t            x_q, x_d, y_q, y_d;
    logic            sx_q, sx_d, sy_q, sy_d;
    logic            pend_h_q, pend_h_d, pend_v_q, pend_v_d;
    logic            active_q, active_d;
    logic            frame_done_q, frame_done_d;
    logic            miss_q, miss_d;
    logic [NREQ-1:0] grant_q, win;
    logic [1:0]      speed;
    logic            run, upd, launch, vs_rise, sx_new, sy_new, y_out, restart;
    pos_t            x_sum, y_next;

    assign run     = state_q == ST_RUN;
    assign upd     = state_q == ST_UPDATE;
    assign launch  = state_q == ST_IDLE && bus.serve;
    assign vs_rise = bus.vsync & ~vsync_q;
    assign sx_new  = sx_q ^ pend_h_q;
    assign sy_new  = sy_q ^ pend_v_q;
    assign x_sum   = x_q + vel(sx_new, speed);
    assign y_next  = y_q + vel(sy_new, speed);
    assign y_out   = y_next > Y_MAX;
    assign restart = launch | (upd & y_out);

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk  (clk),
        .reset(reset),
        .en   (run),
        .req  (bus.req),
        .gnt  (win)
    );

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        pend_h_d     = pend_h_q | |(win & ~bus.req_axis);
        pend_v_d     = pend_v_q | |(win & bus.req_axis);
        active_d     = active_q;
        frame_done_d = 1'b0;
        miss_d       = 1'b0;
        if (launch) begin
            state_d  = ST_RUN;
            active_d = 1'b1;
            sx_d     = 1'b1;
            sy_d     = 1'b0;
        end else if (run && vs_rise) begin
            state_d = ST_UPDATE;
        end else if (upd) begin
            pend_h_d = 1'b0;
            pend_v_d = 1'b0;
            if (y_out) begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
                x_d      = X_START;
                y_d      = Y_START;
                miss_d   = 1'b1;
            end else begin
                state_d      = ST_RUN;
                // Bit 8 set means the sum left 0..255: bit 7 tells underflow from overflow.
                x_d          = x_sum[8] ? (x_sum[7] ? '0 : X_LIM) : x_sum;
                y_d          = y_next;
                sx_d         = sx_new;
                sy_d         = sy_new;
                frame_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            vsync_q      <= 1'b0;
            x_q          <= X_START;
            y_q          <= Y_START;
            sx_q         <= 1'b1;
            sy_q         <= 1'b0;
            pend_h_q     <= 1'b0;
            pend_v_q     <= 1'b0;
            active_q     <= 1'b0;
            frame_done_q <= 1'b0;
            miss_q       <= 1'b0;
            grant_q      <= '0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= bus.vsync;
            x_q          <= x_d;
            y_q          <= y_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            pend_h_q     <= pend_h_d;
            pend_v_q     <= pend_v_d;
            active_q     <= active_d;
            frame_done_q <= frame_done_d;
            miss_q       <= miss_d;
            grant_q      <= win;
        end
    end

`ifdef BALL_SPEEDUP_EN
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] speed_q, speed_d;
    always_comb begin
        cnt_d   = restart ? 3'd0 : cnt_q + 3'(win[REQ_PADDLE]);
        speed_d = restart ? 2'd1 :
                  (win[REQ_PADDLE] && cnt_q == 3'd7 && speed_q != 2'd3) ? speed_q + 2'd1 : speed_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 3'd0;
            speed_q <= 2'd1;
        end else begin
            cnt_q   <= cnt_d;
            speed_q <= speed_d;
        end
    end
    assign speed = speed_q;
`else
    assign speed = 2'd1;
`endif

    assign bus.grant       = grant_q;
    assign bus.ball_x      = x_q;
    assign bus.ball_y      = y_q;
    assign bus.ball_active = active_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.miss        = miss_q;
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: directed and random frames against a frame-level model of
// ball motion, round-robin grants and miss/serve behaviour.
module tb_ball_motion_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    int m_x, m_y, m_sx, m_sy, m_speed, m_pcnt, m_ptr;
    bit m_active, m_fh, m_fv;

    ball_motion_ctrl_if #(.NREQ(4)) bus();
    ball_motion_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 128; m_y = 120; m_sx = -1; m_sy = 1; m_speed = 1; m_pcnt = 0;
        m_ptr = 0; m_active = 0; m_fh = 0; m_fv = 0;
    endtask

    function automatic int rr_pick(input logic [3:0] p, input int ptr);
        for (int k = 0; k < 4; k++)
            if (p[(ptr + k) % 4]) return (ptr + k) % 4;
        return 0;
    endfunction

    task automatic paddle_grant();
`ifdef BALL_SPEEDUP_EN
        m_pcnt++;
        if (m_pcnt == 8) begin
            m_pcnt = 0;
            if (m_speed < 3) m_speed++;
        end
`endif
    endtask

    task automatic serve_ball();
        bus.serve = 1'b1;
        @(posedge clk); #1;
        bus.serve = 1'b0;
        m_active = 1; m_sx = -1; m_sy = 1; m_speed = 1; m_pcnt = 0;
        check("serve_active", 32'(bus.ball_active), 32'd1);
    endtask

    task automatic check_ball(input string tag);
        check({tag, "_x"}, 32'(bus.ball_x), 32'(m_x));
        check({tag, "_y"}, 32'(bus.ball_y), 32'(m_y));
        check({tag, "_active"}, 32'(bus.ball_active), 32'(m_active));
    endtask

    // One frame: requesters in rmask are held until granted, then a vsync edge.
    task automatic frame(input logic [3:0] rmask, input logic [3:0] amask);
        logic [3:0] pend;
        int w, nx, ny;
        bit mis;
        if (!m_active) serve_ball();
        pend = rmask;
        bus.req_axis = amask;
        bus.req = pend;
        for (int c = 0; c < 4 && pend != 4'd0; c++) begin
            w = rr_pick(pend, m_ptr);
            @(posedge clk); #1;
            check("grant", 32'(bus.grant), 32'(1) << w);
            m_ptr = (w + 1) % 4;
            if (amask[w]) m_fv = 1; else m_fh = 1;
            if (w == 2) paddle_grant();
            pend[w] = 1'b0;
            bus.req = pend;
        end
        bus.vsync = 1'b1;
        @(posedge clk); #1;
        check("grant_quiet", 32'(bus.grant), 32'd0);
        check("fd_early", 32'(bus.frame_done), 32'd0);
        @(posedge clk); #1;
        if (m_fh) m_sx = -m_sx;
        if (m_fv) m_sy = -m_sy;
        m_fh = 0; m_fv = 0;
        nx = m_x + m_sx * m_speed;
        nx = nx < 0 ? 0 : (nx > 255 ? 255 : nx);
        ny = m_y + m_sy * m_speed;
        mis = ny < 0 || ny > 239;
        if (mis) begin
            m_active = 0; m_x = 128; m_y = 120; m_speed = 1; m_pcnt = 0;
        end else begin
            m_x = nx; m_y = ny;
        end
        check_ball("frame");
        check("frame_done", 32'(bus.frame_done), 32'(!mis));
        check("miss", 32'(bus.miss), 32'(mis));
        bus.vsync = 1'b0;
        @(posedge clk); #1;
        check("fd_pulse", 32'(bus.frame_done), 32'd0);
        check("miss_pulse", 32'(bus.miss), 32'd0);
    endtask

    initial begin
        bus.vsync = 1'b0; bus.serve = 1'b0; bus.req = '0; bus.req_axis = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_ball("reset");
        check("reset_grant", 32'(bus.grant), 32'd0);
        check("reset_fd", 32'(bus.frame_done), 32'd0);
        check("reset_miss", 32'(bus.miss), 32'd0);
        reset = 1'b0;
        // Idle: vsyncs and requests are ignored.
        bus.req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            bus.vsync = 1'b1;
            repeat (2) begin
                @(posedge clk); #1;
                check("idle_fd", 32'(bus.frame_done), 32'd0);
                check("idle_grant", 32'(bus.grant), 32'd0);
            end
            bus.vsync = 1'b0;
            @(posedge clk); #1;
        end
        bus.req = '0;
        check_ball("idle");
        // Serve together with a vsync edge: serve wins, no movement.
        bus.serve = 1'b1; bus.vsync = 1'b1;
        @(posedge clk); #1;
        bus.serve = 1'b0;
        m_active = 1;
        repeat (2) @(posedge clk);
        #1;
        check_ball("serve_vs");
        check("serve_vs_fd", 32'(bus.frame_done), 32'd0);
        bus.vsync = 1'b0;
        @(posedge clk); #1;
        frame(4'b0000, 4'b0000);
        frame(4'b0101, 4'b0010);
        frame(4'b1001, 4'b0000);
        for (int i = 0; i < 40; i++) frame(4'($urandom), 4'($urandom));
        for (int i = 0; i < 8; i++) frame(4'b0100, 4'b0000);
        // Walk x to the left edge, then the right, keeping y oscillating.
        for (int i = 0; i < 300 && m_x != 0; i++)
            frame({2'b00, 1'(i % 2), 1'(m_sx > 0)}, 4'b0010);
        frame({3'b000, 1'(m_sx > 0)}, 4'b0010);
        for (int i = 0; i < 300 && m_x != 255; i++)
            frame({2'b00, 1'(i % 2), 1'(m_sx < 0)}, 4'b0010);
        frame({3'b000, 1'(m_sx < 0)}, 4'b0010);
        // Let y run off the bottom.
        for (int i = 0; i < 300 && m_active; i++)
            frame({2'b00, 1'(m_sy < 0), 1'b0}, 4'b0010);
        check("miss_reached", 32'(bus.ball_active), 32'd0);
        frame(4'b0000, 4'b0000);
        // Async reset while in UPDATE discards the pending flip.
        bus.req_axis = 4'b0000; bus.req = 4'b0001;
        @(posedge clk); #1;
        bus.req = '0; bus.vsync = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_ball("areset");
        check("areset_grant", 32'(bus.grant), 32'd0);
        check("areset_fd", 32'(bus.frame_done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; bus.vsync = 1'b0;
        @(posedge clk); #1;
        frame(4'b0000, 4'b0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
